load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences one RV64 load or store at a time onto a simple request/ack
//   data bus. Misaligned or illegal-funct3 accesses fault without touching
//   the bus. An access that gets no bus_ack within TIMEOUT request cycles
//   also faults. Load results are byte-extracted and then sign- or
//   zero-extended into a registered load_data.
//
//   Ports
//     clk_i, rst_i       clock, synchronous active-high reset
//     mem_op_valid_i     core access request; held stable while stall_o=1
//     mem_we_i           1 = store, 0 = load
//     mem_funct3_i       RV64 load/store funct3
//     mem_addr_i         byte address
//     mem_wdata_i        store data, LSB-justified
//     stall_o            freezes the core while an access is outstanding
//     load_data_o        extended load result (registered)
//     load_valid_o       one-cycle pulse on a successful load
//     fault_o            one-cycle pulse on misaligned/illegal/timed-out access
//     bus_req_o          bus request, held until bus_ack_i
//     bus_we_o           bus write enable
//     bus_addr_o         doubleword-aligned bus address
//     bus_wdata_o        store data shifted into its byte lane(s)
//     bus_wmask_o        byte enables (0 for loads)
//     bus_rdata_i        bus read data, valid with bus_ack_i
//     bus_ack_i          one-cycle completion strobe
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for mem_op_valid_i; checks legality of the access
//   REQ   | bus request outstanding; counts cycles without bus_ack_i
//   DONE  | one cycle reporting load_valid_o / fault_o, then IDLE

module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_op_valid_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [63:0] mem_addr_i,
    input  logic [63:0] mem_wdata_i,
    output logic        stall_o,
    output logic [63:0] load_data_o,
    output logic        load_valid_o,
    output logic        fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [63:0] bus_addr_o,
    output logic [63:0] bus_wdata_o,
    output logic [7:0]  bus_wmask_o,
    input  logic [63:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The wait counter value seen in the last permitted REQ cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,      state_d;
    logic [7:0]  wait_cnt_q,   wait_cnt_d;
    logic        bus_req_q,    bus_req_d;
    logic        bus_we_q,     bus_we_d;
    logic [63:0] bus_addr_q,   bus_addr_d;
    logic [63:0] bus_wdata_q,  bus_wdata_d;
    logic [7:0]  bus_wmask_q,  bus_wmask_d;
    logic [2:0]  funct3_q,     funct3_d;
    logic [2:0]  off_q,        off_d;
    logic [63:0] load_data_q,  load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q,      fault_d;

    // Access decode for the request currently presented by the core.
    logic [2:0]  acc_off;
    logic        acc_illegal;
    logic        acc_misalign;
    logic [7:0]  lane_base;
    logic [7:0]  st_mask;
    logic [63:0] st_data;

    assign acc_off = mem_addr_i[2:0];

    always_comb begin
        acc_illegal = mem_we_i ? mem_funct3_i[2] : (mem_funct3_i == 3'b111);
        case (mem_funct3_i[1:0])
            2'd0: begin
                acc_misalign = 1'b0;
                lane_base    = 8'h01;
            end
            2'd1: begin
                acc_misalign = acc_off[0];
                lane_base    = 8'h03;
            end
            2'd2: begin
                acc_misalign = |acc_off[1:0];
                lane_base    = 8'h0F;
            end
            default: begin
                acc_misalign = |acc_off;
                lane_base    = 8'hFF;
            end
        endcase
    end

    assign st_mask = lane_base << acc_off;
    assign st_data = mem_wdata_i << {acc_off, 3'b000};

    // Load extraction uses the funct3/offset captured on REQ entry, so the
    // result does not depend on the core keeping its inputs stable in REQ.
    logic [63:0] ld_shift;
    logic [63:0] ld_ext;

    assign ld_shift = bus_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b011:  ld_ext = ld_shift;
            3'b100:  ld_ext = {56'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {48'd0, ld_shift[15:0]};
            3'b110:  ld_ext = {32'd0, ld_shift[31:0]};
            default: ld_ext = 64'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wmask_d  = bus_wmask_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op_valid_i) begin
                    if (acc_illegal || acc_misalign) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                        if (!mem_we_i) begin
                            load_data_d = 64'd0;
                        end
                    end else begin
                        state_d     = S_REQ;
                        wait_cnt_d  = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_we_i;
                        bus_addr_d  = {mem_addr_i[63:3], 3'b000};
                        bus_wdata_d = mem_we_i ? st_data : 64'd0;
                        bus_wmask_d = mem_we_i ? st_mask : 8'd0;
                        funct3_d    = mem_funct3_i;
                        off_d       = acc_off;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack_i) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_data_d  = ld_ext;
                        load_valid_d = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    if (!bus_we_q) begin
                        load_data_d = 64'd0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                // DONE (and any unused encoding) returns to IDLE; the core's
                // request is deliberately not looked at here.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 64'd0;
            bus_wdata_q  <= 64'd0;
            bus_wmask_q  <= 8'd0;
            funct3_q     <= 3'd0;
            off_q        <= 3'd0;
            load_data_q  <= 64'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wmask_q  <= bus_wmask_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:  stall_o = mem_op_valid_i;
            S_REQ:   stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign fault_o      = fault_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_wmask_o  = bus_wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Scoreboard bench for load_store_unit. The driver issues accesses and
//   pushes the expected bus transaction, result pulse and stall window into
//   queues; independent monitors compare whenever the DUT shows bus_req,
//   load_valid/fault, and every cycle for stall.

module tb_load_store_unit;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_op_valid;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        stall;
    logic [63:0] load_data;
    logic        load_valid;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic [63:0] bus_rdata;
    logic        bus_ack;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_op_valid_i (mem_op_valid),
        .mem_we_i       (mem_we),
        .mem_funct3_i   (mem_funct3),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .stall_o        (stall),
        .load_data_o    (load_data),
        .load_valid_o   (load_valid),
        .fault_o        (fault),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_wdata_o    (bus_wdata),
        .bus_wmask_o    (bus_wmask),
        .bus_rdata_i    (bus_rdata),
        .bus_ack_i      (bus_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    typedef struct { int cyc; bit lv; bit flt; logic [63:0] data; } pulse_t;
    typedef struct { logic [63:0] addr; bit we; logic [63:0] wdata; logic [7:0] mask; int n; } bus_t;
    typedef struct { int from; int to; } win_t;

    pulse_t pulse_q[$];
    bus_t   bus_q[$];
    win_t   win_q[$];

    logic [63:0] model_ld = 64'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Reference load: gather the addressed bytes, then extend.
    function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
        int nb;
        logic [63:0] v;
        nb = nbytes(f3);
        v  = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1]) begin
            for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [2:0] f3, input int off);
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < nbytes(f3); i++) m[off+i] = 1'b1;
        return m;
    endfunction

    task automatic idle_inputs();
        mem_op_valid = 1'b0;
        mem_we       = 1'($urandom % 2);
        mem_funct3   = 3'($urandom % 8);
        mem_addr     = rnd64();
        mem_wdata    = rnd64();
        bus_ack      = 1'($urandom % 2);
        bus_rdata    = rnd64();
    endtask

    // Valid-looking request while the DUT is in DONE; it must be ignored.
    task automatic garbage_inputs();
        idle_inputs();
        mem_op_valid = 1'b1;
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
    // d: REQ cycle index carrying bus_ack (>= TO means never).
    // rst_k: REQ cycle index during which rst is asserted (-1 = none).
    task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int d, input int rst_k);
        int nb, off, n, c0;
        bit legal, tmo;
        pulse_t p;
        bus_t b;
        win_t w;
        nb    = nbytes(f3);
        off   = int'(addr[2:0]);
        legal = (we ? (f3 < 3'd4) : (f3 != 3'd7)) && ((off % nb) == 0);
        c0    = cyc;

        mem_op_valid = 1'b1;
        mem_we       = we;
        mem_funct3   = f3;
        mem_addr     = addr;
        mem_wdata    = wd;
        bus_ack      = 1'($urandom % 2);
        bus_rdata    = rnd64();

        if (!legal) begin
            if (!we) model_ld = 64'd0;
            p = '{cyc: c0 + 1, lv: 1'b0, flt: 1'b1, data: model_ld};
            pulse_q.push_back(p);
            w = '{from: c0, to: c0};
            win_q.push_back(w);
            @(posedge clk); #1;
            garbage_inputs();
            @(posedge clk); #1;
            idle_inputs();
            return;
        end

        tmo = (d >= TO);
        n   = tmo ? TO : d + 1;
        if (rst_k >= 0) n = rst_k + 1;
        b = '{addr: {addr[63:3], 3'b000}, we: we, wdata: wd << (8*off),
              mask: we ? ref_mask(f3, off) : 8'd0, n: n};
        bus_q.push_back(b);
        w = '{from: c0, to: c0 + n};
        win_q.push_back(w);
        if (rst_k >= 0) begin
            model_ld = 64'd0;
        end else if (tmo) begin
            if (!we) model_ld = 64'd0;
            p = '{cyc: c0 + n + 1, lv: 1'b0, flt: 1'b1, data: model_ld};
            pulse_q.push_back(p);
        end else if (!we) begin
            model_ld = ref_load(rd, f3, off);
            p = '{cyc: c0 + n + 1, lv: 1'b1, flt: 1'b0, data: model_ld};
            pulse_q.push_back(p);
        end

        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bus_ack   = (k == d);
            bus_rdata = (k == d) ? rd : rnd64();
            if (k == rst_k) rst = 1'b1;
            @(posedge clk); #1;
        end

        if (rst_k >= 0) begin
            rst = 1'b0;
            idle_inputs();
            chk("rst_bus_req",   64'(bus_req),   64'd0);
            chk("rst_bus_we",    64'(bus_we),    64'd0);
            chk("rst_bus_wmask", 64'(bus_wmask), 64'd0);
            chk("rst_bus_addr",  bus_addr,       64'd0);
            chk("rst_bus_wdata", bus_wdata,      64'd0);
            chk("rst_load_data", load_data,      64'd0);
            chk("rst_lv",        64'(load_valid), 64'd0);
            chk("rst_fault",     64'(fault),     64'd0);
            @(posedge clk); #1;
            chk("rst_lv_after",    64'(load_valid), 64'd0);
            chk("rst_fault_after", 64'(fault),      64'd0);
            return;
        end
        garbage_inputs();
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Stall monitor: compared every cycle against the expected windows.
    bit stall_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            while (win_q.size() > 0 && win_q[0].to < cyc) void'(win_q.pop_front());
            stall_exp = (win_q.size() > 0) && (cyc >= win_q[0].from);
            chk("stall", 64'(stall), 64'(stall_exp));
        end
    end

    // Result monitor: pops on every load_valid/fault pulse.
    pulse_t mp;
    always @(negedge clk) begin
        if (mon_en && (load_valid || fault)) begin
            if (pulse_q.size() == 0) begin
                chk("unexpected_pulse", {62'd0, fault, load_valid}, 64'd0);
            end else begin
                mp = pulse_q.pop_front();
                chk("pulse_cycle", 64'(cyc), 64'(mp.cyc));
                chk("load_valid",  64'(load_valid), 64'(mp.lv));
                chk("fault",       64'(fault), 64'(mp.flt));
                chk("load_data",   load_data, mp.data);
            end
        end
    end

    // Bus monitor: compares fields when bus_req rises, stability while high,
    // and the number of request cycles when it falls.
    bus_t mb;
    bit   in_bus = 1'b0;
    bit   bus_stable;
    int   bus_cnt;
    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_mask;
    logic        cap_we;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_req && !in_bus) begin
                in_bus     = 1'b1;
                bus_cnt    = 1;
                bus_stable = 1'b1;
                cap_addr   = bus_addr;
                cap_wdata  = bus_wdata;
                cap_mask   = bus_wmask;
                cap_we     = bus_we;
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", 64'(bus_req), 64'd0);
                    mb = '{addr: 64'd0, we: 1'b0, wdata: 64'd0, mask: 8'd0, n: 0};
                end else begin
                    mb = bus_q.pop_front();
                    chk("bus_addr",  bus_addr,        mb.addr);
                    chk("bus_we",    64'(bus_we),    64'(mb.we));
                    chk("bus_wmask", 64'(bus_wmask), 64'(mb.mask));
                    if (mb.we) chk("bus_wdata", bus_wdata, mb.wdata);
                end
            end else if (bus_req && in_bus) begin
                bus_cnt++;
                if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                    bus_wmask !== cap_mask || bus_we !== cap_we) bus_stable = 1'b0;
            end else if (!bus_req && in_bus) begin
                in_bus = 1'b0;
                chk("bus_req_cycles", 64'(bus_cnt), 64'(mb.n));
                chk("bus_fields_stable", 64'(bus_stable), 64'd1);
            end
        end
    end

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [63:0] a;
        int          off, nb, r, d;

        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall",     64'(stall),      64'd0);
        chk("reset_bus_req",   64'(bus_req),    64'd0);
        chk("reset_lv",        64'(load_valid), 64'd0);
        chk("reset_fault",     64'(fault),      64'd0);
        chk("reset_load_data", load_data,       64'd0);
        chk("reset_bus_wmask", 64'(bus_wmask),  64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // LB at 0x1003, ack in first REQ cycle.
        issue(1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, -1);
        chk("lb_1003_data", load_data, 64'hFFFF_FFFF_FFFF_FF80);
        // SH at 0x2006, ack after 3 wait cycles.
        issue(1'b1, 3'b001, 64'h2006, 64'hBEEF, rnd64(), 3, -1);
        // Misaligned LW.
        issue(1'b0, 3'b010, 64'h3002, rnd64(), rnd64(), 0, -1);
        chk("lw_3002_data", load_data, 64'd0);
        // LD that never gets an ack.
        issue(1'b0, 3'b011, 64'h5000, 64'd0, rnd64(), TO + 5, -1);
        // Ack on the very last permitted REQ cycle.
        issue(1'b0, 3'b011, 64'h5008, 64'd0, 64'h0123_4567_89AB_CDEF, TO - 1, -1);
        chk("ld_last_cycle_data", load_data, 64'h0123_4567_89AB_CDEF);
        // Illegal funct3 store and load.
        issue(1'b1, 3'b100, 64'h6000, rnd64(), rnd64(), 0, -1);
        issue(1'b0, 3'b111, 64'h6008, rnd64(), rnd64(), 0, -1);
        // Reset during REQ of an LWU, then a clean LWU.
        issue(1'b0, 3'b110, 64'h4000, 64'd0, rnd64(), TO + 5, 1);
        issue(1'b0, 3'b110, 64'h4004, 64'd0, 64'hFFFF_FFFF_0000_0000, 0, -1);
        chk("lwu_4004_data", load_data, 64'h0000_0000_FFFF_FFFF);

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom % 2);
            if (we) f3 = ($urandom % 8 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
            else    f3 = 3'($urandom % 8);
            nb  = nbytes(f3);
            off = int'($urandom % 8);
            if ($urandom % 3 != 0) off = off - (off % nb);
            a = rnd64();
            a[2:0] = 3'(off);
            r = int'($urandom % 20);
            if (r == 0)      d = TO + int'($urandom % 3);
            else if (r == 1) d = TO - 1;
            else             d = int'($urandom % 6);
            issue(we, f3, a, rnd64(), rnd64(), d, -1);
            repeat ($urandom % 3) begin
                idle_inputs();
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pulse_queue_empty", 64'(pulse_q.size()), 64'd0);
        chk("bus_queue_empty",   64'(bus_q.size()),   64'd0);
        chk("final_load_data",   load_data,           model_ld);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
